sap_controller_sequencer: RTL and testbench

SAP-1 controller-sequencer: a six-state ring counter plus a decoder that turns the instruction-register opcode into the 12-bit control word. It reads what the instruction register stores and drives every load and enable line in the datapath: PC, MAR, RAM, IR, A, ALU, B and the output register. It sits between the instruction register's upper nibble and all datapath control inputs, and supplies the halt signal to the clock stage.

---
 rtl/sap_controller_sequencer.sv | 127 ++++++++++++
 tb/tb_sap_controller_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sap_controller_sequencer.sv
// SAP-1 controller-sequencer: one-hot T1..T6 ring counter, sticky halt and opcode-to-control-word decoder.
// Optional build macro SAP_VARIABLE_MACHINE_CYCLE_EN returns to T1 right after the last useful execute state.
module sap_controller_sequencer (
    input  logic        CLK,
    input  logic        CLR_BAR,
    input  logic [3:0]  OPCODE,
    output logic [11:0] CON,
    output logic [5:0]  T,
    output logic        HLT
);

    typedef enum logic [5:0] {
        ST_T1 = 6'b000001,
        ST_T2 = 6'b000010,
        ST_T3 = 6'b000100,
        ST_T4 = 6'b001000,
        ST_T5 = 6'b010000,
        ST_T6 = 6'b100000
    } ring_e;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Control word bit order: {Cp, Ep, LM_BAR, CE_BAR, LI_BAR, EI_BAR, LA_BAR, EA, Su, EU, LB_BAR, LO_BAR}
    localparam logic [11:0] CW_NOP      = 12'h3E3;
    localparam logic [11:0] CW_FETCH_T1 = 12'h5E3;
    localparam logic [11:0] CW_FETCH_T2 = 12'hBE3;
    localparam logic [11:0] CW_FETCH_T3 = 12'h263;
    localparam logic [11:0] CW_IR_TO_MAR = 12'h1A3;
    localparam logic [11:0] CW_RAM_TO_A = 12'h2C3;
    localparam logic [11:0] CW_RAM_TO_B = 12'h2E1;
    localparam logic [11:0] CW_ADD_TO_A = 12'h3C7;
    localparam logic [11:0] CW_SUB_TO_A = 12'h3CF;
    localparam logic [11:0] CW_A_TO_OUT = 12'h3F2;

    ring_e       ring_q, ring_d;
    logic        hlt_q, hlt_d;
    logic [11:0] con_w;

    always_comb begin
        ring_d = ring_q;
        hlt_d  = hlt_q;
        if (!hlt_q) begin
            case (ring_q)
                ST_T1: ring_d = ST_T2;
                ST_T2: ring_d = ST_T3;
                ST_T3: ring_d = ST_T4;
                ST_T4: begin
                    // A halting instruction parks the ring in T4 for good.
                    if (OPCODE == OP_HLT) begin
                        hlt_d = 1'b1;
                    end else begin
`ifdef SAP_VARIABLE_MACHINE_CYCLE_EN
                        if ((OPCODE == OP_LDA) || (OPCODE == OP_ADD) || (OPCODE == OP_SUB)) begin
                            ring_d = ST_T5;
                        end else begin
                            ring_d = ST_T1;
                        end
`else
                        ring_d = ST_T5;
`endif
                    end
                end
                ST_T5: begin
`ifdef SAP_VARIABLE_MACHINE_CYCLE_EN
                    ring_d = (OPCODE == OP_LDA) ? ST_T1 : ST_T6;
`else
                    ring_d = ST_T6;
`endif
                end
                ST_T6:   ring_d = ST_T1;
                default: ring_d = ST_T1;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge CLR_BAR) begin
        if (!CLR_BAR) begin
            ring_q <= ST_T1;
            hlt_q  <= 1'b0;
        end else begin
            ring_q <= ring_d;
            hlt_q  <= hlt_d;
        end
    end

    always_comb begin
        con_w = CW_NOP;
        if (!hlt_q) begin
            case (ring_q)
                ST_T1: con_w = CW_FETCH_T1;
                ST_T2: con_w = CW_FETCH_T2;
                ST_T3: con_w = CW_FETCH_T3;
                ST_T4: begin
                    case (OPCODE)
                        OP_LDA, OP_ADD, OP_SUB: con_w = CW_IR_TO_MAR;
                        OP_OUT:                 con_w = CW_A_TO_OUT;
                        default:                con_w = CW_NOP;
                    endcase
                end
                ST_T5: begin
                    case (OPCODE)
                        OP_LDA:         con_w = CW_RAM_TO_A;
                        OP_ADD, OP_SUB: con_w = CW_RAM_TO_B;
                        default:        con_w = CW_NOP;
                    endcase
                end
                ST_T6: begin
                    case (OPCODE)
                        OP_ADD:  con_w = CW_ADD_TO_A;
                        OP_SUB:  con_w = CW_SUB_TO_A;
                        default: con_w = CW_NOP;
                    endcase
                end
                default: con_w = CW_NOP;
            endcase
        end
    end

    assign CON = con_w;
    assign T   = ring_q;
    assign HLT = hlt_q;

endmodule

// File: tb/tb_sap_controller_sequencer.sv
// Bench for sap_controller_sequencer: directed reset/fetch/execute/halt steps plus random instruction stream
// checked against a per-instruction list of expected control words.
module tb_sap_controller_sequencer;

    logic        clk = 1'b0;
    logic        clr_bar;
    logic [3:0]  opcode;
    logic [11:0] con;
    logic [5:0]  t;
    logic        hlt;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    sap_controller_sequencer dut (
        .CLK     (clk),
        .CLR_BAR (clr_bar),
        .OPCODE  (opcode),
        .CON     (con),
        .T       (t),
        .HLT     (hlt)
    );

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Whole-instruction reference: the control word of every cycle from T1 until the return to T1.
    task automatic load_expected(input logic [3:0] op);
        exp_q.delete();
        exp_q.push_back(12'h5E3);
        exp_q.push_back(12'hBE3);
        exp_q.push_back(12'h263);
        case (op)
            4'b0000: begin
                exp_q.push_back(12'h1A3);
                exp_q.push_back(12'h2C3);
`ifndef SAP_VARIABLE_MACHINE_CYCLE_EN
                exp_q.push_back(12'h3E3);
`endif
            end
            4'b0001: begin
                exp_q.push_back(12'h1A3);
                exp_q.push_back(12'h2E1);
                exp_q.push_back(12'h3C7);
            end
            4'b0010: begin
                exp_q.push_back(12'h1A3);
                exp_q.push_back(12'h2E1);
                exp_q.push_back(12'h3CF);
            end
            4'b1110: begin
                exp_q.push_back(12'h3F2);
`ifndef SAP_VARIABLE_MACHINE_CYCLE_EN
                exp_q.push_back(12'h3E3);
                exp_q.push_back(12'h3E3);
`endif
            end
            default: begin
                exp_q.push_back(12'h3E3);
`ifndef SAP_VARIABLE_MACHINE_CYCLE_EN
                exp_q.push_back(12'h3E3);
                exp_q.push_back(12'h3E3);
`endif
            end
        endcase
    endtask

    // Runs the first n cycles of an instruction (n < 0: all of it); entered just after a T1-starting edge.
    task automatic run_steps(input logic [3:0] op, input int n);
        int n_run;
        load_expected(op);
        n_run = (n < 0) ? exp_q.size() : n;
        for (int i = 0; i < n_run; i++) begin
            @(negedge clk);
            check($sformatf("ring_op%h_step%0d", op, i), {6'b0, t}, 12'(1 << i));
            check($sformatf("con_op%h_step%0d", op, i), con, exp_q[i]);
            check($sformatf("hlt_op%h_step%0d", op, i), {11'b0, hlt}, 12'h000);
            @(posedge clk);
            #1;
            if (i == 2) opcode = op;
        end
    endtask

    task automatic run_instr(input logic [3:0] op);
        run_steps(op, -1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_t"}, {6'b0, t}, 12'h001);
        check({tag, "_con"}, con, 12'h5E3);
        check({tag, "_hlt"}, {11'b0, hlt}, 12'h000);
    endtask

    task automatic run_halt();
        run_steps(4'b1111, 3);
        @(negedge clk);
        check("halt_t4_t", {6'b0, t}, 12'h008);
        check("halt_t4_con", con, 12'h3E3);
        check("halt_t4_hlt", {11'b0, hlt}, 12'h000);
        for (int k = 0; k < 21; k++) begin
            @(posedge clk);
            #1;
            opcode = 4'($urandom_range(0, 15));
            @(negedge clk);
            check($sformatf("halted_t_%0d", k), {6'b0, t}, 12'h008);
            check($sformatf("halted_con_%0d", k), con, 12'h3E3);
            check($sformatf("halted_hlt_%0d", k), {11'b0, hlt}, 12'h001);
        end
        #2;
        clr_bar = 1'b0;
        #1;
        check_reset_values("halt_clear");
        @(posedge clk);
        #1;
        check_reset_values("halt_clear_held");
        clr_bar = 1'b1;
        opcode  = 4'b0000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int cycles;
        logic [3:0] op;
        clr_bar = 1'b0;
        opcode  = 4'b0000;
        @(posedge clk);
        #1;
        check_reset_values("por");
        clr_bar = 1'b1;

        // Abort an LDA in T5 with an asynchronous reset, then restart the fetch.
        run_steps(4'b0000, 4);
        #3;
        clr_bar = 1'b0;
        #1;
        check_reset_values("mid_t5_reset");
        @(posedge clk);
        #1;
        check_reset_values("mid_t5_reset_held");
        clr_bar = 1'b1;

        run_instr(4'b0000);
        run_instr(4'b0001);
        run_instr(4'b0010);
        run_instr(4'b1110);
        run_instr(4'b0101);
        run_instr(4'b0000);
        run_halt();

        cycles = 0;
        while (cycles < 100) begin
            op = 4'($urandom_range(0, 14));
            run_instr(op);
            cycles += exp_q.size();
        end

        run_instr(4'b0010);
        run_halt();
        run_instr(4'b1110);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
